bcd_scan_decoder: RTL and testbench
===================================

// Module: bcd_scan_decoder
// PURPOSE
//   Multi-digit, time-multiplexed BCD-to-decimal one-hot decoder for display/indicator scanning.
//   Latches an N-digit packed BCD word, steps through digits at a programmable rate and presents
//   the current digit as a 10-bit one-hot pattern plus a one-hot digit strobe.
//   Adds invalid-code flagging, leading-zero blanking and tear-free word updates (frame boundary).
//   Sits between counter/arith datapaths and the board display driver.
// PARAMETERS
//   NUM_DIGITS  4     digits scanned, >=2; digit 0 = least significant
//   SCAN_DIV    1000  clk cycles each digit is held, >=1
//   IDX_W       derived localparam = $clog2(NUM_DIGITS)
// PORTS
//   clk         in   1            system clock, rising edge
//   rst         in   1            asynchronous reset, active-high
//   load        in   1            strobe: capture bcd_in this cycle
//   bcd_in      in   4*NUM_DIGITS packed BCD; digit k = bcd_in[4k+3:4k]
//   blank_lz    in   1            1 = suppress leading zeros
//   dec_out     out  10           one-hot decimal of current digit (bit d = value d)
//   digit_sel   out  NUM_DIGITS   one-hot strobe of digit being shown
//   digit_idx   out  IDX_W        index of digit being shown
//   err         out  1            current digit code is 10..15
//   frame_done  out  1            1-cycle pulse when scan wraps NUM_DIGITS-1 -> 0
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): state IDLE; prescaler, idx, active word, shadow word,
//     pending = 0; all outputs 0. Deassertion: first action on next rising clk edge.
//   FSM IDLE: outputs held 0; load -> active <= bcd_in, idx <= 0, prescaler <= 0, go SCAN.
//   FSM SCAN: prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it clears and idx advances;
//     idx NUM_DIGITS-1 -> 0 is the wrap. SCAN never returns to IDLE except via rst.
//   Load during SCAN (non-wrap cycle): shadow <= bcd_in, pending <= 1; repeated loads: last wins.
//   Wrap cycle: if load same cycle, active <= bcd_in directly, pending <= 0; else if pending,
//     active <= shadow, pending <= 0. Active word never changes mid-frame.
//   Outputs registered: decode of (idx, active) appears 1 clk after idx/active update.
//     First digit visible 2 clks after IDLE load.
//   Decode: code 0..9 -> dec_out = 1<<code, err = 0; code 10..15 -> dec_out = 0, err = 1.
//   Blanking (blank_lz=1): digit k blanked if all digits k..NUM_DIGITS-1 of active word are 0;
//     digit 0 never blanked. Blanked: dec_out = 0, err = 0, digit_sel still asserted.
//     Invalid code is nonzero, so it stops blanking. blank_lz sampled live, takes effect next output.
//   digit_sel = 1<<idx in SCAN, exactly one bit high; digit_idx = idx.
//   frame_done asserts on the output cycle showing digit 0 after a wrap (not the first frame after IDLE).
//   SCAN_DIV=1: idx advances every clk; all rules above hold unchanged.
// STRUCTURE
//   Package bcd_scan_pkg: BCD_W=4, DEC_W=10, state encoding {ST_IDLE, ST_SCAN}.
//   Sub-module bcd_onehot_dec: combinational 4-bit code -> {err, dec[9:0]}, one instance on the
//     muxed current digit. The top level holds the FSM, prescaler, idx counter, shadow/pending,
//     blank mask and output registers.
// TESTING (bench: NUM_DIGITS=4, SCAN_DIV=4)
//   rst, then idle 10 clks -> all outputs 0, no frame_done.
//   load bcd_in=16'h1905 -> idx 0..3 each held 4 clks.
//     dec_out 0x020, 0x001, 0x200, 0x002 with digit_sel 1, 2, 4, 8; frame_done on wrap.
//   load 16'h0042, blank_lz=1 -> digit 3,2 dec_out 0, sel 8, 4 still high.
//     digit1 0x010, digit0 0x004; 16'h0000 -> digit0 shows 0x001.
//   load 16'h3B27 -> digit2 err=1, dec_out=0; other digits decode normally.
//   Mid-frame loads 16'h1111 then 16'h2222 at idx 1 -> rest of frame shows old word.
//     After wrap, shows 2222 only.
//   Load coincident with wrap cycle -> new word shown from digit 0 of the next frame.
//   rst pulse at idx 2 mid-hold (async, between edges) -> outputs 0 immediately, IDLE.
//     Requires a new load to restart.

Source files
------------

// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared widths and FSM encoding for the BCD scan decoder
package bcd_scan_pkg;
  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/bcd_onehot_dec.sv
// rtl/bcd_onehot_dec.sv - combinational 4-bit BCD code to one-hot decimal with invalid flag
module bcd_onehot_dec
  import bcd_scan_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [DEC_W-1:0] dec,
  output logic             err
);

  always_comb begin
    dec = '0;
    err = 1'b0;
    if (code <= BCD_W'(9)) begin
      dec = DEC_W'(1) << code;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_scan_decoder.sv
// rtl/bcd_scan_decoder.sv - time-multiplexed N-digit BCD scanner with blanking and frame-aligned word updates
module bcd_scan_decoder
  import bcd_scan_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int SCAN_DIV   = 1000,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [BCD_W*NUM_DIGITS-1:0]   bcd_in,
  input  logic                          blank_lz,
  output logic [DEC_W-1:0]              dec_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [IDX_W-1:0]              digit_idx,
  output logic                          err,
  output logic                          frame_done
);

  localparam int               PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int               WORD_W    = BCD_W * NUM_DIGITS;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  state_t              state, state_nxt;
  logic [PW-1:0]       presc, presc_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [WORD_W-1:0]   active, active_nxt;
  logic [WORD_W-1:0]   shadow, shadow_nxt;
  logic                pending, pending_nxt;
  logic                wrapped, wrapped_nxt;
  logic                tick, wrap;

  logic [BCD_W-1:0]      cur_code;
  logic [DEC_W-1:0]      dec_raw;
  logic                  err_raw;
  logic [NUM_DIGITS-1:0] zero_hi;
  logic                  blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      presc   <= '0;
      idx     <= '0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      idx     <= idx_nxt;
      active  <= active_nxt;
      shadow  <= shadow_nxt;
      pending <= pending_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  // The active word only swaps on the wrap edge so a frame is never torn.
  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    idx_nxt     = idx;
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    wrapped_nxt = 1'b0;
    tick        = 1'b0;
    wrap        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nxt  = ST_SCAN;
          active_nxt = bcd_in;
          idx_nxt    = '0;
          presc_nxt  = '0;
        end
      end
      ST_SCAN: begin
        tick        = (presc == PRESC_MAX);
        wrap        = tick && (idx == LAST_IDX);
        presc_nxt   = tick ? '0 : presc + PW'(1);
        wrapped_nxt = wrap;
        if (tick) begin
          idx_nxt = wrap ? '0 : idx + IDX_W'(1);
        end
        if (wrap) begin
          if (load) begin
            active_nxt  = bcd_in;
            pending_nxt = 1'b0;
          end else if (pending) begin
            active_nxt  = shadow;
            pending_nxt = 1'b0;
          end
        end else if (load) begin
          shadow_nxt  = bcd_in;
          pending_nxt = 1'b1;
        end
      end
    endcase
  end

  assign cur_code = active[idx*BCD_W +: BCD_W];

  // zero_hi[k]: digits k..NUM_DIGITS-1 of the active word are all zero.
  always_comb begin
    zero_hi = '0;
    zero_hi[NUM_DIGITS-1] = (active[WORD_W-1 -: BCD_W] == '0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_hi[k] = (active[k*BCD_W +: BCD_W] == '0) && zero_hi[k+1];
    end
  end

  assign blank = blank_lz && (idx != '0) && zero_hi[idx];

  bcd_onehot_dec u_dec (
    .code (cur_code),
    .dec  (dec_raw),
    .err  (err_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_out    <= '0;
      digit_sel  <= '0;
      digit_idx  <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else if (state == ST_SCAN) begin
      dec_out    <= blank ? '0 : dec_raw;
      err        <= blank ? 1'b0 : err_raw;
      digit_sel  <= NUM_DIGITS'(1) << idx;
      digit_idx  <= idx;
      frame_done <= wrapped;
    end else begin
      dec_out    <= '0;
      digit_sel  <= '0;
      digit_idx  <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// tb/tb_bcd_scan_decoder.sv - directed self-checking bench for bcd_scan_decoder (4 digits, divide by 4)
module tb_bcd_scan_decoder;
  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic [9:0]  dec_out;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        err;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  bcd_scan_decoder #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .blank_lz   (blank_lz),
    .dec_out    (dec_out),
    .digit_sel  (digit_sel),
    .digit_idx  (digit_idx),
    .err        (err),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic adv_to(input int n);
    while (t < n) step();
  endtask

  task automatic chk(input string tag, input logic [9:0] e_dec, input logic [3:0] e_sel,
                     input logic [1:0] e_idx, input logic e_err, input logic e_fd);
    checks++;
    assert (dec_out === e_dec) else begin
      failures++;
      $error("FAIL %s dec_out got=%h exp=%h", tag, dec_out, e_dec);
    end
    checks++;
    assert (digit_sel === e_sel) else begin
      failures++;
      $error("FAIL %s digit_sel got=%b exp=%b", tag, digit_sel, e_sel);
    end
    checks++;
    assert (digit_idx === e_idx) else begin
      failures++;
      $error("FAIL %s digit_idx got=%0d exp=%0d", tag, digit_idx, e_idx);
    end
    checks++;
    assert (err === e_err) else begin
      failures++;
      $error("FAIL %s err got=%b exp=%b", tag, err, e_err);
    end
    checks++;
    assert (frame_done === e_fd) else begin
      failures++;
      $error("FAIL %s frame_done got=%b exp=%b", tag, frame_done, e_fd);
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    blank_lz = 1'b0;
    #12;
    chk("rst_hold", 10'h000, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", 10'h000, 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Word 1905 from IDLE; t counts edges from the capture edge.
    bcd_in = 16'h1905;
    load   = 1'b1;
    step();
    load   = 1'b0;
    t      = 1;
    adv_to(2);  chk("w1905_d0",     10'h020, 4'b0001, 2'd0, 1'b0, 1'b0);
    adv_to(5);  chk("w1905_d0_end", 10'h020, 4'b0001, 2'd0, 1'b0, 1'b0);
    adv_to(6);  chk("w1905_d1",     10'h001, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(10); chk("w1905_d2",     10'h200, 4'b0100, 2'd2, 1'b0, 1'b0);
    adv_to(14); chk("w1905_d3",     10'h002, 4'b1000, 2'd3, 1'b0, 1'b0);
    adv_to(17); chk("w1905_d3_end", 10'h002, 4'b1000, 2'd3, 1'b0, 1'b0);
    adv_to(18); chk("w1905_wrap",   10'h020, 4'b0001, 2'd0, 1'b0, 1'b1);
    adv_to(19); chk("w1905_fd_off", 10'h020, 4'b0001, 2'd0, 1'b0, 1'b0);

    // Word 0042 with leading-zero blanking, loaded mid-frame.
    blank_lz = 1'b1;
    bcd_in   = 16'h0042;
    load     = 1'b1;
    adv_to(20);
    load     = 1'b0;
    adv_to(22); chk("old_1905_d1",  10'h001, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(34); chk("w0042_d0",     10'h004, 4'b0001, 2'd0, 1'b0, 1'b1);
    adv_to(38); chk("w0042_d1",     10'h010, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(42); chk("w0042_d2_blk", 10'h000, 4'b0100, 2'd2, 1'b0, 1'b0);
    adv_to(46); chk("w0042_d3_blk", 10'h000, 4'b1000, 2'd3, 1'b0, 1'b0);

    bcd_in = 16'h0000;
    load   = 1'b1;
    adv_to(47);
    load   = 1'b0;
    adv_to(50); chk("w0000_d0",     10'h001, 4'b0001, 2'd0, 1'b0, 1'b1);
    adv_to(54); chk("w0000_d1_blk", 10'h000, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(57); chk("w0000_d1_end", 10'h000, 4'b0010, 2'd1, 1'b0, 1'b0);
    blank_lz = 1'b0;
    adv_to(58); chk("w0000_d2_live", 10'h001, 4'b0100, 2'd2, 1'b0, 1'b0);

    // Word 3B27: invalid code in digit 2.
    bcd_in = 16'h3B27;
    load   = 1'b1;
    adv_to(59);
    load   = 1'b0;
    adv_to(66); chk("w3b27_d0",     10'h080, 4'b0001, 2'd0, 1'b0, 1'b1);
    adv_to(70); chk("w3b27_d1",     10'h004, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(74); chk("w3b27_d2_err", 10'h000, 4'b0100, 2'd2, 1'b1, 1'b0);
    adv_to(78); chk("w3b27_d3",     10'h008, 4'b1000, 2'd3, 1'b0, 1'b0);

    // Two loads while idx=1: old word holds for the frame, last load wins after wrap.
    adv_to(85);
    bcd_in = 16'h1111;
    load   = 1'b1;
    adv_to(86);
    bcd_in = 16'h2222;
    adv_to(87);
    load   = 1'b0;
    adv_to(90);  chk("hold_old_d2",  10'h000, 4'b0100, 2'd2, 1'b1, 1'b0);
    adv_to(94);  chk("hold_old_d3",  10'h008, 4'b1000, 2'd3, 1'b0, 1'b0);
    adv_to(98);  chk("w2222_d0",     10'h004, 4'b0001, 2'd0, 1'b0, 1'b1);
    adv_to(102); chk("w2222_d1",     10'h004, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(106); chk("w2222_d2",     10'h004, 4'b0100, 2'd2, 1'b0, 1'b0);
    adv_to(110); chk("w2222_d3",     10'h004, 4'b1000, 2'd3, 1'b0, 1'b0);

    // Load in the wrap cycle goes straight into the next frame.
    adv_to(112);
    bcd_in = 16'h5678;
    load   = 1'b1;
    adv_to(113);
    load   = 1'b0;
    chk("wrapload_prev_d3", 10'h004, 4'b1000, 2'd3, 1'b0, 1'b0);
    adv_to(114); chk("w5678_d0", 10'h100, 4'b0001, 2'd0, 1'b0, 1'b1);
    adv_to(118); chk("w5678_d1", 10'h080, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(122); chk("w5678_d2", 10'h040, 4'b0100, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset between edges while digit 2 is held.
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 10'h000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_after_rst", 10'h000, 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    bcd_in = 16'h0009;
    load   = 1'b1;
    step();
    load   = 1'b0;
    t      = 1;
    adv_to(2);  chk("restart_d0",   10'h200, 4'b0001, 2'd0, 1'b0, 1'b0);
    adv_to(6);  chk("restart_d1",   10'h001, 4'b0010, 2'd1, 1'b0, 1'b0);
    adv_to(18); chk("restart_wrap", 10'h200, 4'b0001, 2'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
